// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA sequencer: halts the core, copies one 256-byte page to the OAM port.
// Define OAM_DMA_PARITY_ALIGN_EN to insert the odd-cycle ALIGN tick.
module oam_dma_controller #(
  parameter logic [15:0] P_trigger_addr = 16'h4014,
  parameter logic [15:0] P_target_addr  = 16'h2004,
  parameter int          P_count_width  = 8
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic [15:0] I_host_addr,
  input  logic [7:0]  I_host_data,
  input  logic        I_host_wren,
  input  logic        I_host_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic        O_halt,
  output logic        O_active,
  output logic [15:0] O_addr,
  output logic [7:0]  O_data,
  output logic        O_rdwr,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
`ifdef OAM_DMA_PARITY_ALIGN_EN
    S_ALIGN,
`endif
    S_READ,
    S_WRITE
  } state_t;

  typedef logic [P_count_width-1:0] cnt_t;

  state_t     state;
  logic [7:0] page;
  cnt_t       count;
`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic       parity;
`endif

  function automatic logic [15:0] src_addr(
    input logic [7:0] pg,
    input cnt_t       c
  );
    return {pg, 8'h00} + 16'(c);
  endfunction

  // O_data doubles as the read latch: it only reaches the bus in WRITE.
  always_ff @(posedge I_clock) begin
    if (!I_reset) begin
      state    <= S_IDLE;
      page     <= '0;
      count    <= '0;
`ifdef OAM_DMA_PARITY_ALIGN_EN
      parity   <= 1'b0;
`endif
      O_halt   <= 1'b0;
      O_active <= 1'b0;
      O_addr   <= '0;
      O_data   <= '0;
      O_rdwr   <= 1'b0;
      O_busy   <= 1'b0;
    end else if (I_tick) begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
      parity <= ~parity;
`endif
      unique case (state)
        S_IDLE: begin
          if (I_host_wren &&
              I_host_addr == P_trigger_addr) begin
            page   <= I_host_data;
            count  <= '0;
            state  <= S_HALT;
            O_halt <= 1'b1;
            O_busy <= 1'b1;
          end
        end
        S_HALT: begin
          if (I_host_rdwr) begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
            if (parity) begin
              state <= S_ALIGN;
            end else begin
              state    <= S_READ;
              O_active <= 1'b1;
              O_rdwr   <= 1'b1;
              O_addr   <= src_addr(page, count);
            end
`else
            state    <= S_READ;
            O_active <= 1'b1;
            O_rdwr   <= 1'b1;
            O_addr   <= src_addr(page, count);
`endif
          end
        end
`ifdef OAM_DMA_PARITY_ALIGN_EN
        S_ALIGN: begin
          state    <= S_READ;
          O_active <= 1'b1;
          O_rdwr   <= 1'b1;
          O_addr   <= src_addr(page, count);
        end
`endif
        S_READ: begin
          state  <= S_WRITE;
          O_data <= I_rd_data;
          O_rdwr <= 1'b0;
          O_addr <= P_target_addr;
        end
        S_WRITE: begin
          count <= count + 1'b1;
          if (count == '1) begin
            state    <= S_IDLE;
            O_halt   <= 1'b0;
            O_busy   <= 1'b0;
            O_active <= 1'b0;
            O_addr   <= '0;
            O_data   <= '0;
            O_rdwr   <= 1'b0;
          end else begin
            state  <= S_READ;
            O_data <= '0;
            O_rdwr <= 1'b1;
            O_addr <= src_addr(page, count + 1'b1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: cycle-indexed transfer model plus directed scenarios.
// Honours OAM_DMA_PARITY_ALIGN_EN the same way the design does.
module tb_oam_dma_controller;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [15:0] haddr;
  logic [7:0]  hdata;
  logic        wren;
  logic        rdwr;
  logic [7:0]  rd_data;
  logic        o_halt;
  logic        o_active;
  logic [15:0] o_addr;
  logic [7:0]  o_data;
  logic        o_rdwr;
  logic        o_busy;

  always #5 clk = ~clk;

  oam_dma_controller dut (
    .I_clock     (clk),
    .I_reset     (rst_n),
    .I_tick      (tick),
    .I_host_addr (haddr),
    .I_host_data (hdata),
    .I_host_wren (wren),
    .I_host_rdwr (rdwr),
    .I_rd_data   (rd_data),
    .O_halt      (o_halt),
    .O_active    (o_active),
    .O_addr      (o_addr),
    .O_data      (o_data),
    .O_rdwr      (o_rdwr),
    .O_busy      (o_busy)
  );

  // Memory image: byte at xxNN holds NN ^ A5
  assign rd_data = (o_active && o_rdwr) ? (o_addr[7:0] ^ 8'hA5) : 8'h00;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: phase 0 idle, 1 halt, 2 align, 3 bus cycles k=0..511
  int         m_phase = 0;
  int         m_k = 0;
  logic [7:0] m_page = 8'h00;
  bit         m_par = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_k = 0;
      m_par = 1'b0;
    end else if (tick) begin
      case (m_phase)
        0: if (wren && haddr == 16'h4014) begin
             m_page = hdata;
             m_phase = 1;
           end
        1: if (rdwr) begin
             m_k = 0;
             m_phase = (ALIGN_EN && m_par) ? 2 : 3;
           end
        2: m_phase = 3;
        default: if (m_k == 511) m_phase = 0;
                 else m_k++;
      endcase
      m_par = !m_par;
    end
  end

  bit          started = 1'b0;
  int          halt_cnt = 0;
  int          idle_halt = 0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];

  always @(negedge clk) begin
    if (started) begin
      logic        e_act;
      logic        e_wr;
      logic [15:0] e_addr;
      e_act = (m_phase == 3);
      e_wr = e_act && (m_k % 2 == 1);
      e_addr = !e_act ? 16'h0000 :
               e_wr ? 16'h2004 : {m_page, 8'(m_k / 2)};
      chk("halt", 32'(o_halt), 32'(m_phase != 0));
      chk("busy", 32'(o_busy), 32'(m_phase != 0));
      chk("active", 32'(o_active), 32'(e_act));
      chk("addr", 32'(o_addr), 32'(e_addr));
      chk("rdwr", 32'(o_rdwr), 32'(e_act && !e_wr));
      if (e_wr)
        chk("data", 32'(o_data), 32'(8'(m_k / 2) ^ 8'hA5));
      else if (!e_act)
        chk("data_idle", 32'(o_data), 32'h0);
      if (tick && o_halt) halt_cnt++;
      if (tick && o_halt && !o_active) idle_halt++;
      if (tick && o_active) begin
        if (o_rdwr) rd_q.push_back(o_addr);
        else begin
          wr_a.push_back(o_addr);
          wr_d.push_back(o_data);
        end
      end
    end
  end

  task automatic drive(input bit t, input bit w,
                       input logic [15:0] a,
                       input logic [7:0] d, input bit r);
    tick = t;
    wren = w;
    haddr = a;
    hdata = d;
    rdwr = r;
    @(posedge clk);
    #1;
  endtask

  // mode 1: retrigger at count 10, 2: reset at write 40, 3: freeze ticks
  task automatic run_xfer(input logic [7:0] pg, input bit odd,
                          input int nw, input int mode);
    bit need;
    bit frozen;
    int guard;
    need = odd ^ bit'((nw + 1) % 2);
    if (m_par != need) drive(1, 0, 16'h8000, 8'h00, 1);
    rd_q.delete();
    wr_a.delete();
    wr_d.delete();
    halt_cnt = 0;
    idle_halt = 0;
    frozen = 1'b0;
    drive(1, 1, 16'h4014, pg, 0);
    repeat (nw) drive(1, 1, 16'h0300, 8'h11, 0);
    guard = 0;
    while (m_phase != 0 && guard < 3000) begin
      guard++;
      if (mode == 1 && m_phase == 3 && m_k == 32)
        drive(1, 1, 16'h4014, 8'h07, 0);
      else if (mode == 2 && m_phase == 3 && m_k == 129) begin
        rst_n = 1'b0;
        drive(1, 0, 16'h8000, 8'h00, 1);
        rst_n = 1'b1;
      end else if (mode == 3 && m_phase == 3 &&
                   m_k == 100 && !frozen) begin
        frozen = 1'b1;
        repeat (5) drive(0, 0, 16'h8000, 8'h00, 1);
      end else
        drive(1, 0, 16'h8000, 8'h00, 1);
    end
    chk("xfer_timeout", 32'(guard < 3000), 32'h1);
  endtask

  task automatic post_checks(input logic [7:0] pg,
                             input int exp_halt,
                             input int exp_idle);
    int bad;
    chk("halt_ticks", 32'(halt_cnt), 32'(exp_halt));
    chk("halt_no_bus", 32'(idle_halt), 32'(exp_idle));
    chk("n_reads", 32'(rd_q.size()), 32'd256);
    chk("n_writes", 32'(wr_a.size()), 32'd256);
    if (rd_q.size() == 256 && wr_d.size() == 256) begin
      chk("rd_first", 32'(rd_q[0]), 32'({pg, 8'h00}));
      chk("rd_last", 32'(rd_q[255]), 32'({pg, 8'hFF}));
      chk("wr_d0", 32'(wr_d[0]), 32'h0A5);
      chk("wr_d1", 32'(wr_d[1]), 32'h0A4);
      chk("wr_d255", 32'(wr_d[255]), 32'h05A);
    end
    bad = 0;
    foreach (wr_a[i]) if (wr_a[i] != 16'h2004) bad++;
    foreach (rd_q[i]) if (rd_q[i][15:8] != pg) bad++;
    chk("addr_stream", 32'(bad), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    wren = 1'b0;
    haddr = 16'h0000;
    hdata = 8'h00;
    rdwr = 1'b1;
    @(posedge clk);
    #1;
    started = 1'b1;
    // trigger coincident with reset must lose
    drive(1, 1, 16'h4014, 8'h02, 0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_halt", 32'(o_halt), 32'h0);
    chk("rst_addr", 32'(o_addr), 32'h0);
    rst_n = 1'b1;
    drive(1, 0, 16'h8000, 8'h00, 1);

    run_xfer(8'h02, 1'b0, 0, 0);
    post_checks(8'h02, 513, 1);

    run_xfer(8'h02, 1'b1, 0, 0);
    post_checks(8'h02, 513 + int'(ALIGN_EN), 1 + int'(ALIGN_EN));

    run_xfer(8'h02, 1'b0, 2, 0);
    post_checks(8'h02, 515, 3);

    run_xfer(8'h02, 1'b0, 0, 1);
    post_checks(8'h02, 513, 1);

    run_xfer(8'h02, 1'b0, 0, 2);
    chk("rstmid_halt", 32'(o_halt), 32'h0);
    chk("rstmid_active", 32'(o_active), 32'h0);
    chk("rstmid_busy", 32'(o_busy), 32'h0);
    chk("rstmid_writes", 32'(wr_a.size()), 32'd65);
    repeat (10) drive(1, 0, 16'h8000, 8'h00, 1);
    chk("rstmid_no_more", 32'(wr_a.size()), 32'd65);

    run_xfer(8'h03, 1'b0, 0, 0);
    post_checks(8'h03, 513, 1);

    run_xfer(8'h02, 1'b0, 0, 3);
    post_checks(8'h02, 513, 1);

    repeat (3) drive(1, 0, 16'h8000, 8'h00, 1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
